ex_stage: RTL

Execute stage of the five-stage MIPS pipeline, between ID and MEM. Latches the ID→EX bus, runs the 12-op ALU and a multi-cycle HI/LO unit (mult/multu single-cycle, div/divu iterative), and issues data-SRAM requests. It also drives the forwarding and load-use signals back to ID, and stalls the pipeline while a divide is in flight.

---
 rtl/ex_stage_pkg.sv | 36 +++
 rtl/ex_stage_div_iter.sv | 88 ++++++++
 rtl/ex_stage.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared widths, stall encoding, HI/LO funct codes and divider states
//
// Purpose: constants and types used by ex_stage and div_iter.
// Ports:   none (package).
package ex_stage_pkg;

  localparam int STALL_BUS    = 6;
  localparam int ID_TO_EX_WD  = 159;
  localparam int EX_TO_MEM_WD = 76;
  localparam int EX_TO_ID_WD  = 38;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_stage_div_iter.sv
// rtl/ex_stage_div_iter.sv - 32-cycle restoring divider with IDLE/BUSY/DONE control
//
// Purpose: iterative signed/unsigned 32-bit divide for the HI/LO unit.
// Ports:   clk, rst (sync, active-high); start (request, honoured in IDLE only);
//          signed_op; a (dividend), b (divisor); ack (release DONE);
//          busy, done (state flags); quo, rem (valid while done).
module div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  div_state_t  state, state_next;
  logic [4:0]  count;
  logic [31:0] q_reg, r_reg, d_reg, a_keep;
  logic        neg_q, neg_r, by_zero;
  logic [32:0] shifted, diff;

  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE: if (start) state_next = DIV_BUSY;
      DIV_BUSY: if (count == 5'd31) state_next = DIV_DONE;
      DIV_DONE: if (ack) state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  // One restoring step: bring in the next dividend bit and subtract if it fits.
  // The partial remainder is always below the divisor, so the shifted value
  // stays under 2^33 and the borrow bit is a clean "does not fit" flag.
  assign shifted = {r_reg, q_reg[31]};
  assign diff    = shifted - {1'b0, d_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      q_reg   <= '0;
      r_reg   <= '0;
      d_reg   <= '0;
      a_keep  <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      by_zero <= 1'b0;
    end else if (state == DIV_IDLE && start) begin
      count   <= '0;
      q_reg   <= mag32(a, signed_op & a[31]);
      d_reg   <= mag32(b, signed_op & b[31]);
      r_reg   <= '0;
      a_keep  <= a;
      neg_q   <= signed_op & (a[31] ^ b[31]);
      neg_r   <= signed_op & a[31];
      by_zero <= (b == 32'd0);
    end else if (state == DIV_BUSY) begin
      count <= count + 5'd1;
      if (!diff[32]) begin
        r_reg <= diff[31:0];
        q_reg <= {q_reg[30:0], 1'b1};
      end else begin
        r_reg <= shifted[31:0];
        q_reg <= {q_reg[30:0], 1'b0};
      end
    end
  end

  // Divide by zero bypasses sign fix-up so signed and unsigned agree:
  // quotient all ones, remainder the original dividend.
  assign quo  = by_zero ? 32'hFFFF_FFFF : mag32(q_reg, neg_q);
  assign rem  = by_zero ? a_keep        : mag32(r_reg, neg_r);
  assign busy = (state == DIV_BUSY);
  assign done = (state == DIV_DONE);

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: ALU, HI/LO unit, data-SRAM request, forwarding
//
// Purpose: latches the ID->EX bus, computes ALU/HI-LO results and drives MEM,
//          the ID forwarding path, load-use flag and the divide stall request.
// Ports:   clk, rst (sync, active-high); stall (bit 2 EX, bit 3 MEM);
//          id_to_ex_bus in; ex_to_mem_bus, ex_to_id_bus out; is_lw;
//          stallreq_for_ex; data_sram_en/wen/addr/wdata.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_BUS-1:0]    stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
  output logic                    is_lw,
  output logic                    stallreq_for_ex,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata
);

  logic [ID_TO_EX_WD-1:0] ex_reg;

  always_ff @(posedge clk) begin
    if (rst)                                         ex_reg <= '0;
    else if (stall[2] == STOP && stall[3] == NO_STOP) ex_reg <= '0;
    else if (stall[2] == NO_STOP)                     ex_reg <= id_to_ex_bus;
  end

  logic [31:0] pc, inst, rdata1, rdata2;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2;
  logic        ram_en, rf_we, sel_rf_res;
  logic [3:0]  ram_wen;
  logic [4:0]  rf_waddr;

  assign pc         = ex_reg[158:127];
  assign inst       = ex_reg[126:95];
  assign alu_op     = ex_reg[94:83];
  assign sel_src1   = ex_reg[82:80];
  assign sel_src2   = ex_reg[79:76];
  assign ram_en     = ex_reg[75];
  assign ram_wen    = ex_reg[74:71];
  assign rf_we      = ex_reg[70];
  assign rf_waddr   = ex_reg[69:65];
  assign sel_rf_res = ex_reg[64];
  assign rdata1     = ex_reg[63:32];
  assign rdata2     = ex_reg[31:0];

  // ALU operands (one-hot selects, AND-OR muxed)
  logic [31:0] src1, src2, imm_sext, imm_zext;
  assign imm_sext = {{16{inst[15]}}, inst[15:0]};
  assign imm_zext = {16'd0, inst[15:0]};
  assign src1 = ({32{sel_src1[0]}} & rdata1)
              | ({32{sel_src1[1]}} & pc)
              | ({32{sel_src1[2]}} & {27'd0, inst[10:6]});
  assign src2 = ({32{sel_src2[0]}} & rdata2)
              | ({32{sel_src2[1]}} & imm_sext)
              | ({32{sel_src2[2]}} & 32'd8)
              | ({32{sel_src2[3]}} & imm_zext);

  // alu_op bit 11..0 = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui
  logic [31:0] sra_res, alu_res;
  assign sra_res = $unsigned($signed(src2) >>> src1[4:0]);
  assign alu_res = ({32{alu_op[11]}} & (src1 + src2))
                 | ({32{alu_op[10]}} & (src1 - src2))
                 | ({32{alu_op[9]}}  & {31'd0, $signed(src1) < $signed(src2)})
                 | ({32{alu_op[8]}}  & {31'd0, src1 < src2})
                 | ({32{alu_op[7]}}  & (src1 & src2))
                 | ({32{alu_op[6]}}  & ~(src1 | src2))
                 | ({32{alu_op[5]}}  & (src1 | src2))
                 | ({32{alu_op[4]}}  & (src1 ^ src2))
                 | ({32{alu_op[3]}}  & (src2 << src1[4:0]))
                 | ({32{alu_op[2]}}  & (src2 >> src1[4:0]))
                 | ({32{alu_op[1]}}  & sra_res)
                 | ({32{alu_op[0]}}  & {src2[15:0], 16'd0});

  // HI/LO ops are decoded here rather than carried on the bus
  logic special, is_mfhi, is_mflo, is_mthi, is_mtlo, is_mult, is_multu, is_div, is_divu;
  assign special  = (inst[31:26] == 6'd0);
  assign is_mfhi  = special && inst[5:0] == FUNCT_MFHI;
  assign is_mflo  = special && inst[5:0] == FUNCT_MFLO;
  assign is_mthi  = special && inst[5:0] == FUNCT_MTHI;
  assign is_mtlo  = special && inst[5:0] == FUNCT_MTLO;
  assign is_mult  = special && inst[5:0] == FUNCT_MULT;
  assign is_multu = special && inst[5:0] == FUNCT_MULTU;
  assign is_div   = special && inst[5:0] == FUNCT_DIV;
  assign is_divu  = special && inst[5:0] == FUNCT_DIVU;

  // Sign-extending to 64 bits makes one unsigned multiplier serve both forms.
  logic [63:0] prod, mul_a, mul_b;
  assign mul_a = {{32{is_mult & rdata1[31]}}, rdata1};
  assign mul_b = {{32{is_mult & rdata2[31]}}, rdata2};
  assign prod  = mul_a * mul_b;

  logic        div_start, div_busy, div_done, div_ack;
  logic [31:0] div_quo, div_rem;
  assign div_start = is_div | is_divu;
  assign div_ack   = (stall[2] == NO_STOP);

  div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .signed_op (is_div),
    .a         (rdata1),
    .b         (rdata2),
    .ack       (div_ack),
    .busy      (div_busy),
    .done      (div_done),
    .quo       (div_quo),
    .rem       (div_rem)
  );

  // Raised combinationally in the first cycle so the divide is held in EX
  // before the FSM has left IDLE; dropped in DONE so the result can retire.
  assign stallreq_for_ex = div_busy | (div_start & ~div_done);

  // Writes only on an advancing edge, so a downstream-held op writes once.
  logic [31:0] hi, lo;
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (stall[2] == NO_STOP) begin
      if (is_mult | is_multu) begin
        hi <= prod[63:32];
        lo <= prod[31:0];
      end else if (div_start & div_done) begin
        hi <= div_rem;
        lo <= div_quo;
      end else if (is_mthi) begin
        hi <= rdata1;
      end else if (is_mtlo) begin
        lo <= rdata1;
      end
    end
  end

  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] result;
  assign rf_we_o    = rf_we | is_mfhi | is_mflo;
  assign rf_waddr_o = (is_mfhi | is_mflo) ? inst[15:11] : rf_waddr;
  assign result     = is_mfhi ? hi : (is_mflo ? lo : alu_res);

  assign ex_to_mem_bus   = {pc, ram_en, ram_wen, sel_rf_res, rf_we_o, rf_waddr_o, result};
  assign ex_to_id_bus    = {rf_we_o, rf_waddr_o, result};
  assign is_lw           = ram_en & ~|ram_wen;
  assign data_sram_en    = ram_en;
  assign data_sram_wen   = ram_wen;
  assign data_sram_addr  = alu_res;
  assign data_sram_wdata = rdata2;

  logic unused_ok;
  assign unused_ok = ^{inst[25:16], stall[5:4], stall[1:0]};

endmodule
